// File: rtl/cmd_phy_pkg.sv
// cmd_phy_pkg: shared definitions for the SD CMD-line PHY.
//   state_t      FSM state encoding
//   RESP_*       resp_type codes (2'b11 is handled as RESP_48)
//   *_LEN        command word, frame and long-response lengths in bits
//   CRC7_POLY    x^7 + x^3 + 1 with the x^7 term implicit
package cmd_phy_pkg;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_48   = 2'b01;
    localparam logic [1:0] RESP_136  = 2'b10;
    localparam int CMD_LEN   = 40;
    localparam int FRAME_LEN = 48;
    localparam int LONG_LEN  = 136;
    localparam logic [6:0] CRC7_POLY = 7'h09;
endpackage

// File: rtl/cmd_phy_crc7.sv
// crc7_serial: bit-serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enabled cycle.
//   clock   in   clock
//   reset   in   asynchronous active-high reset
//   clear   in   synchronous clear to 0 (wins over enable)
//   enable  in   absorb bit_in this cycle
//   bit_in  in   next message bit, MSB first
//   crc     out  running remainder
// Feeding crc[6] back in as bit_in makes the feedback zero, so the register then
// simply shifts left; the transmitter uses this to emit the remainder serially.
module crc7_serial
    import cmd_phy_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    assign fb  = bit_in ^ crc_q[6];
    assign crc = crc_q;

    always_comb begin
        crc_d = clear  ? 7'd0 :
                enable ? ({crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0)) : crc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) crc_q <= '0;
        else       crc_q <= crc_d;
    end
endmodule

// File: rtl/cmd_phy.sv
// cmd_phy: SD host CMD-line serializer/deserializer.
// Sends {word[39:0], CRC7, 1} MSB first, releases the line, then captures a
// 48/136-bit response or times out, and holds the result until acknowledged.
// Optional macro CMD_PHY_CRC_CHECK_EN: enables receive CRC7 checking of 48-bit
// responses; without it crc_error is always 0.
//   clock          in   SD clock, one CMD bit per cycle
//   reset          in   asynchronous active-high reset
//   strobe_in      in   command word valid (accepted only in IDLE)
//   cmd_to_send    in   {start,dir,index[5:0],arg[31:0]}
//   resp_type      in   00 none, 01 48-bit, 10 136-bit, 11 as 01
//   ack_in         in   response consumed
//   idle_in        in   abort to IDLE (priority over everything else)
//   cmd_pin_in     in   CMD line from pad
//   serial_ready   out  high in IDLE
//   ack_out        out  command word accepted this cycle
//   strobe_out     out  result valid, held until ack_in
//   cmd_received   out  response (48-bit right aligned, upper bits zero)
//   time_out       out  no start bit seen, qualified by strobe_out
//   crc_error      out  48-bit response CRC mismatch, qualified by strobe_out
//   cmd_pin_out    out  CMD drive value (1 when released)
//   cmd_pin_oe     out  CMD output enable
module cmd_phy
    import cmd_phy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         strobe_in,
    input  logic [39:0]  cmd_to_send,
    input  logic [1:0]   resp_type,
    input  logic         ack_in,
    input  logic         idle_in,
    input  logic         cmd_pin_in,
    output logic         serial_ready,
    output logic         ack_out,
    output logic         strobe_out,
    output logic [135:0] cmd_received,
    output logic         time_out,
    output logic         crc_error,
    output logic         cmd_pin_out,
    output logic         cmd_pin_oe
);
    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [39:0]    word_q, word_d;
    logic           long_q, long_d;
    logic           none_q, none_d;
    logic [135:0]   rx_q, rx_d;
    logic           to_q, to_d;
    logic           crc_err_q, crc_err_d;
    logic           tx_clear, tx_en, tx_bit;
    logic [6:0]     tx_crc;

    // Word bits first, then the remainder shifted out of the CRC register, then the end bit.
    assign tx_bit = cnt_q < 8'(CMD_LEN)       ? word_q[CMD_LEN-1] :
                    cnt_q < 8'(FRAME_LEN - 1) ? tx_crc[6] : 1'b1;

    crc7_serial u_tx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (tx_clear),
        .enable (tx_en),
        .bit_in (tx_bit),
        .crc    (tx_crc)
    );

`ifdef CMD_PHY_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       rx_en;

    // Covers the start bit (seen in WAIT_RESP) plus the next 39 bits: response bits [47:8].
    assign rx_en = !idle_in && ((state_q == WAIT_RESP && !cmd_pin_in) ||
                                (state_q == RECEIVE && cnt_q < 8'(CMD_LEN)));

    crc7_serial u_rx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (tx_clear),
        .enable (rx_en),
        .bit_in (cmd_pin_in),
        .crc    (rx_crc)
    );
`endif

    assign serial_ready = state_q == IDLE;
    assign ack_out      = state_q == IDLE && strobe_in && !idle_in;
    assign strobe_out   = state_q == DONE && !idle_in;
    assign cmd_pin_oe   = state_q == SEND && !idle_in;
    assign cmd_pin_out  = cmd_pin_oe ? tx_bit : 1'b1;
    assign cmd_received = rx_q;
    assign time_out     = to_q;
    assign crc_error    = crc_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        long_d    = long_q;
        none_d    = none_q;
        rx_d      = rx_q;
        to_d      = to_q;
        crc_err_d = crc_err_q;
        tx_clear  = 1'b0;
        tx_en     = 1'b0;
        if (idle_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (strobe_in) begin
                    word_d    = cmd_to_send;
                    long_d    = resp_type == RESP_136;
                    none_d    = resp_type == RESP_NONE;
                    rx_d      = '0;
                    to_d      = 1'b0;
                    crc_err_d = 1'b0;
                    tx_clear  = 1'b1;
                    cnt_d     = '0;
                    state_d   = SEND;
                end
                SEND: begin
                    tx_en  = 1'b1;
                    word_d = {word_q[38:0], 1'b0};
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'(FRAME_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = none_q ? DONE : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    cnt_d = cnt_q + 8'd1;
                    if (!cmd_pin_in) begin
                        rx_d    = {rx_q[134:0], cmd_pin_in};
                        cnt_d   = 8'd1;
                        state_d = RECEIVE;
                    end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
                end
                RECEIVE: begin
                    rx_d  = {rx_q[134:0], cmd_pin_in};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == (long_q ? 8'(LONG_LEN - 1) : 8'(FRAME_LEN - 1))) begin
                        state_d = DONE;
`ifdef CMD_PHY_CRC_CHECK_EN
                        // rx_q[6:0] already holds response bits [7:1]; the last bit is the end bit.
                        crc_err_d = !long_q && (rx_q[6:0] != rx_crc);
`endif
                    end
                end
                DONE: if (ack_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            long_q    <= 1'b0;
            none_q    <= 1'b0;
            rx_q      <= '0;
            to_q      <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            long_q    <= long_d;
            none_q    <= none_d;
            rx_q      <= rx_d;
            to_q      <= to_d;
            crc_err_q <= crc_err_d;
        end
    end
endmodule
